// File: rtl/showcase_ram_reader_pkg.sv
// Shared definitions for the showcase RAM read path.
// Holds the default widths and the result-extension helper.
package showcase_ram_reader_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 2;
  localparam int unsigned RAM_DATA_WIDTH = 8;
  localparam int unsigned RAM_OUT_WIDTH  = 32;

  // Widest result the helper can produce; callers truncate to their own width.
  localparam int unsigned EXT_MAX_WIDTH  = 64;
  localparam int unsigned EXT_IDX_W      = 6;

  function automatic logic [EXT_MAX_WIDTH-1:0] extend(
    input logic [EXT_MAX_WIDTH-1:0] value,
    input logic                     is_signed,
    input int unsigned              data_width
  );
    logic [EXT_MAX_WIDTH-1:0] result;
    logic                     fill;
    result = '0;
    fill   = is_signed & value[EXT_IDX_W'(data_width - 1)];
    for (int unsigned i = 0; i < EXT_MAX_WIDTH; i++) begin
      result[EXT_IDX_W'(i)] = (i < data_width) ? value[EXT_IDX_W'(i)] : fill;
    end
    return result;
  endfunction

endpackage

// File: rtl/showcase_resp_fifo.sv
// Register-based response FIFO with combinational head output.
// Head output shows the last popped entry while empty.
module showcase_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] prev_ptr;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign vld      = (count != '0);
  assign pop_ok   = pop & vld;
  assign prev_ptr = (rd_ptr == '0) ? LAST_IDX : rd_ptr - 1'b1;
  assign data     = vld ? mem[rd_ptr] : mem[prev_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/showcase_ram_reader.sv
// Read-side controller for the showcase signed-byte RAM.
// Issues credit-limited reads and returns extended bytes through a response FIFO.
module showcase_ram_reader
  import showcase_ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = RAM_OUT_WIDTH,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_signed,
  input  logic                  req_vld,
  output logic                  req_rd,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [OUT_WIDTH-1:0]  resp_data,
  output logic                  resp_vld,
  input  logic                  resp_rd,
  output logic                  busy,
  output logic [15:0]           rd_cnt
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned CRED_W = CNT_W + 1;
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(DEPTH);

  logic [CNT_W-1:0]     fifo_count;
  logic [CRED_W-1:0]    credits;
  logic                 inflight;
  logic                 sign_q;
  logic                 accept;
  logic                 pop;
  logic                 fifo_vld;
  logic [OUT_WIDTH-1:0] ext_data;
  logic [15:0]          cnt_q;

  // A read in flight already owns a FIFO slot, so credits cover both.
  assign credits  = {1'b0, fifo_count} + {{(CRED_W-1){1'b0}}, inflight};
  assign pop      = fifo_vld & resp_rd;
  assign req_rd   = (credits < DEPTH_C) | ((credits == DEPTH_C) & pop);
  assign accept   = req_vld & req_rd;
  assign ram_en   = accept;
  assign ram_addr = req_addr;
  assign resp_vld = fifo_vld;
  assign busy     = inflight | (fifo_count != '0);
  assign rd_cnt   = cnt_q;
  assign ext_data = OUT_WIDTH'(extend(EXT_MAX_WIDTH'(ram_dout), sign_q, DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        sign_q <= req_signed;
      end
      if (pop) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  showcase_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ext_data),
    .pop       (pop),
    .count     (fifo_count),
    .vld       (fifo_vld),
    .data      (resp_data)
  );

endmodule

// File: tb/tb_showcase_ram_reader.sv
// Self-checking bench for showcase_ram_reader: directed scenarios plus a
// randomized run against a transaction-level model of outstanding reads.
module tb_showcase_ram_reader;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_addr;
  logic        req_signed;
  logic        req_vld;
  logic        req_rd;
  logic        ram_en;
  logic [1:0]  ram_addr;
  logic [7:0]  ram_dout = 8'h00;
  logic [31:0] resp_data;
  logic        resp_vld;
  logic        resp_rd;
  logic        busy;
  logic [15:0] rd_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt;
  logic [7:0]  mem [4];

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ent_t;

  showcase_ram_reader #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .OUT_WIDTH  (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_addr   (req_addr),
    .req_signed (req_signed),
    .req_vld    (req_vld),
    .req_rd     (req_rd),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .resp_data  (resp_data),
    .resp_vld   (resp_vld),
    .resp_rd    (resp_rd),
    .busy       (busy),
    .rd_cnt     (rd_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, one-cycle latency
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  function automatic logic [31:0] ref_ext(input logic [1:0] a, input logic s);
    int v;
    v = int'(mem[a]);
    if (s && v >= 128) return 32'(v) + 32'hFFFF_FF00;
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b0; req_addr = '0; req_signed = 1'b0; resp_rd = 1'b0;
    #22;
    checks++; if (req_rd !== 1'b1) begin errors++; $display("FAIL reset_req_rd: got %b want 1", req_rd); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL reset_resp_vld: got %b want 0", resp_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_cnt !== 16'h0) begin errors++; $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_single();
    tick();
    req_addr = 2'd1; req_signed = 1'b0; req_vld = 1'b1; resp_rd = 1'b1;
    #1;
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL single_ram_en: got %b want 1", ram_en); end
    checks++; if (ram_addr !== 2'd1) begin errors++; $display("FAIL single_ram_addr: got %0d want 1", ram_addr); end
    tick();
    req_vld = 1'b0;
    #1;
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld: got %b want 0", resp_vld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick(); #1;
    checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", resp_vld); end
    checks++; if (resp_data !== 32'h0000_0080) begin errors++; $display("FAIL single_data: got %h want 00000080", resp_data); end
    exp_cnt++;
    tick(); #1;
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL single_vld_pulse: got %b want 0", resp_vld); end
    checks++; if (rd_cnt !== exp_cnt) begin errors++; $display("FAIL single_rd_cnt: got %h want %h", rd_cnt, exp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_sign();
    logic [1:0]  addr_t [5] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    logic        sgn_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_t  [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0005};
    resp_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      req_addr = addr_t[i]; req_signed = sgn_t[i]; req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      tick(); #1;
      checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL sign_vld[%0d]: got %b want 1", i, resp_vld); end
      checks++; if (resp_data !== exp_t[i]) begin errors++; $display("FAIL sign_data[%0d]: got %h want %h", i, resp_data, exp_t[i]); end
      exp_cnt++;
    end
    tick(); #1;
    checks++; if (rd_cnt !== exp_cnt) begin errors++; $display("FAIL sign_rd_cnt: got %h want %h", rd_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] a;
    resp_rd = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 4) begin req_vld = 1'b1; req_addr = 2'(k); req_signed = 1'b0; end
      else req_vld = 1'b0;
      #1;
      if (k < 4) begin
        checks++; if (req_rd !== 1'b1) begin errors++; $display("FAIL b2b_req_rd[%0d]: got %b want 1", k, req_rd); end
      end
      if (k >= 2 && k <= 5) begin
        a = 2'(k - 2);
        checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d]: got %b want 1", k, resp_vld); end
        checks++; if (resp_data !== {24'h0, mem[a]}) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, resp_data, {24'h0, mem[a]}); end
        exp_cnt++;
      end
      if (k == 5) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last: got %b want 1", busy); end
      end
      if (k == 6) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop: got %b want 0", busy); end
        checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_end: got %b want 0", resp_vld); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  addr_t [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    logic        rdy_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vld_t  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dat_t  [9] = '{32'h0, 32'h0, 32'h05, 32'h05, 32'h05, 32'h05, 32'h80, 32'hFF, 32'h0};
    for (int k = 0; k < 9; k++) begin
      tick();
      resp_rd = (k >= 5);
      req_signed = 1'b0;
      if (k < 6) begin req_vld = 1'b1; req_addr = addr_t[k]; end
      else req_vld = 1'b0;
      #1;
      if (k < 6) begin
        checks++; if (req_rd !== rdy_t[k]) begin errors++; $display("FAIL bp_req_rd[%0d]: got %b want %b", k, req_rd, rdy_t[k]); end
        checks++; if (ram_en !== rdy_t[k]) begin errors++; $display("FAIL bp_ram_en[%0d]: got %b want %b", k, ram_en, rdy_t[k]); end
      end
      checks++; if (resp_vld !== vld_t[k]) begin errors++; $display("FAIL bp_vld[%0d]: got %b want %b", k, resp_vld, vld_t[k]); end
      if (vld_t[k]) begin
        checks++; if (resp_data !== dat_t[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, resp_data, dat_t[k]); end
      end
      if (k == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b want 0", busy); end
      end
    end
    exp_cnt = exp_cnt + 16'd3;
    checks++; if (rd_cnt !== exp_cnt) begin errors++; $display("FAIL bp_rd_cnt: got %h want %h", rd_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    resp_rd = 1'b0;
    tick();
    req_vld = 1'b1; req_addr = 2'd0; req_signed = 1'b0;
    tick();
    req_addr = 2'd1;
    tick();
    req_vld = 1'b0;
    #1;
    checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre_vld: got %b want 1", resp_vld); end
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL rmid_vld: got %b want 0", resp_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (rd_cnt !== 16'h0) begin errors++; $display("FAIL rmid_rd_cnt: got %h want 0", rd_cnt); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rmid_ram_en: got %b want 0", ram_en); end
    tick();
    rst_n = 1'b1;
    resp_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL rmid_stale[%0d]: got %b want 0", k, resp_vld); end
    end
    checks++; if (rd_cnt !== 16'h0) begin errors++; $display("FAIL rmid_cnt_after: got %h want 0", rd_cnt); end
  endtask

  // Model: every accepted read is outstanding until popped; the head becomes
  // visible two cycles after its accept; credits = outstanding count.
  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic exp_vld, exp_rdy, exp_pop;
    int   n = 600;
    for (int cyc = 0; cyc < n; cyc++) begin
      tick();
      if (cyc < n - 10) begin
        req_vld    = 1'($urandom_range(0, 1));
        req_addr   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        resp_rd    = ($urandom_range(0, 9) < 6);
      end else begin
        req_vld = 1'b0;
        resp_rd = 1'b1;
      end
      #1;
      exp_vld = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      exp_pop = exp_vld & resp_rd;
      exp_rdy = (q.size() < DEPTH) || (q.size() == DEPTH && exp_pop);
      checks++; if (req_rd !== exp_rdy) begin errors++; $display("FAIL rnd_req_rd@%0d: got %b want %b", cyc, req_rd, exp_rdy); end
      checks++; if (ram_en !== (req_vld & exp_rdy)) begin errors++; $display("FAIL rnd_ram_en@%0d: got %b want %b", cyc, ram_en, req_vld & exp_rdy); end
      checks++; if (resp_vld !== exp_vld) begin errors++; $display("FAIL rnd_vld@%0d: got %b want %b", cyc, resp_vld, exp_vld); end
      if (exp_vld) begin
        checks++; if (resp_data !== q[0].data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, resp_data, q[0].data); end
      end
      checks++; if (busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, q.size() != 0); end
      checks++; if (rd_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_rd_cnt@%0d: got %h want %h", cyc, rd_cnt, exp_cnt); end
      if (exp_pop) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (req_vld && exp_rdy) begin
        e.data = ref_ext(req_addr, req_signed);
        e.cyc  = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic test_wrap();
    int p;
    p = 65535 - int'(exp_cnt);
    resp_rd = 1'b1;
    req_signed = 1'b0;
    for (int c = 0; c <= p + 3; c++) begin
      tick();
      req_vld  = 1'b1;
      req_addr = 2'($urandom_range(0, 3));
      #1;
      if (c == p + 2) begin
        checks++; if (rd_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want ffff", rd_cnt); end
      end
      if (c == p + 3) begin
        checks++; if (rd_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", rd_cnt); end
        checks++; if (req_rd !== 1'b1) begin errors++; $display("FAIL wrap_req_rd: got %b want 1", req_rd); end
      end
    end
    for (int d = 0; d < 3; d++) begin
      tick();
      req_vld = 1'b0;
    end
    #1;
    exp_cnt = exp_cnt + 16'(p + 4);
    checks++; if (rd_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_drain_cnt: got %h want %h", rd_cnt, exp_cnt); end
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL wrap_drain_vld: got %b want 0", resp_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_drain_busy: got %b want 0", busy); end
  endtask

  initial begin
    mem[0] = 8'h05; mem[1] = 8'h80; mem[2] = 8'hFF; mem[3] = 8'h7F;
    test_reset();
    test_single();
    test_sign();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
